register_file_sync_reset_n: RTL

- Parametrised multi-register successor to the single W-bit enabled register: DEPTH registers of W bits each.
- Provides one synchronous write port, two combinational read ports, and a dedicated load path for the top register (program-counter style value, e.g. PC+8).
- Sits in the datapath of the single-cycle/multi-cycle processor between instruction decode and the ALU operand muxes.

---
 rtl/register_file_sync_reset_n.sv | 71 +++++++
 1 files changed

// File: rtl/register_file_sync_reset_n.sv
// DEPTH x W register file: one synchronous write port, a special load path into
// register DEPTH-1, and two combinational read ports. Optional macro: REGFILE_WRITE_BYPASS_EN.
module register_file_sync_reset_n #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned A     = 4
) (
    input  logic         clk,
    input  logic         reset_synchronous_n,
    input  logic         write_enable,
    input  logic [A-1:0] write_addr,
    input  logic [W-1:0] write_data,
    input  logic         special_load,
    input  logic [W-1:0] special_data,
    input  logic [A-1:0] read_addr_a,
    input  logic [A-1:0] read_addr_b,
    output logic [W-1:0] read_data_a,
    output logic [W-1:0] read_data_b
);

    localparam logic [A-1:0] LAST = A'(DEPTH - 1);

    logic [W-1:0] regs [DEPTH];
    logic         wr_in_range;
    logic         wr_hits_last;
    logic         special_go;

    assign wr_in_range  = (32'(write_addr) < DEPTH);
    assign wr_hits_last = write_enable && (write_addr == LAST);
    // A general write to the top register takes priority over the special load.
    assign special_go   = special_load && !wr_hits_last;

    always_ff @(posedge clk) begin
        if (!reset_synchronous_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (special_go) begin
                regs[LAST] <= special_data;
            end
            if (write_enable && wr_in_range) begin
                regs[write_addr] <= write_data;
            end
        end
    end

    function automatic logic [W-1:0] read_port(input logic [A-1:0] addr);
        logic [W-1:0] value;
        value = '0;
        if (32'(addr) < DEPTH) begin
            value = regs[addr];
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (reset_synchronous_n) begin
            if (write_enable && wr_in_range && (addr == write_addr)) begin
                value = write_data;
            end else if (special_go && (addr == LAST)) begin
                value = special_data;
            end
        end
`endif
        return value;
    endfunction

    always_comb begin
        read_data_a = read_port(read_addr_a);
        read_data_b = read_port(read_addr_b);
    end

endmodule
